// File: rtl/mito_pkg.sv
// Shared MITO definitions: layer codes and phase encodings used by the
// layer controller and the layer phase sequencer.
package mito_pkg;

  localparam logic [1:0] LAYER_NONE = 2'b00;
  localparam logic [1:0] LAYER_CONV = 2'b01;
  localparam logic [1:0] LAYER_POOL = 2'b10;
  localparam logic [1:0] LAYER_FC   = 2'b11;

  typedef enum logic [3:0] {
    PH_IDLE    = 4'b0000,
    PH_READ    = 4'b0100,
    PH_COMP    = 4'b0101,
    PH_WRITE   = 4'b0110,
    PH_INIT    = 4'b0111,
    PH_SUSPEND = 4'b1000,
    PH_FINISH  = 4'b1001
  } phase_t;

  // A layer may start only if it is real and not the one just finished.
  function automatic logic layer_startable(
    input logic [1:0] layer,
    input logic [1:0] done_layer
  );
    return (layer != LAYER_NONE) && (layer != done_layer);
  endfunction

endpackage

// File: rtl/layer_phase_sequencer_tile_counter.sv
// Tile counter: loads zero plus a last-tile index, increments per tile.
// Ports: clk, rst, i_load, i_inc, i_last_idx -> o_idx, o_last.
module tile_counter #(
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [TILE_W-1:0] i_last_idx,
  output logic [TILE_W-1:0] o_idx,
  output logic              o_last
);

  logic [TILE_W-1:0] r_idx;
  logic [TILE_W-1:0] r_last_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (i_load) begin
      r_idx      <= '0;
      r_last_idx <= i_last_idx;
    end else if (i_inc) begin
      r_idx      <= r_idx + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == r_last_idx);

endmodule

// File: rtl/layer_phase_sequencer.sv
// Per-layer phase engine: INIT, (READ, COMP, WRITE) per tile, FINISH.
// In: clk, rst, layer_type, rd_done, comp_done, wr_done, ofm_full.
// Out: phase, cur_layer, tile_idx, rd_req, comp_start, wr_req,
//      ofm_valid, busy. All outputs come from registered state.
module layer_phase_sequencer
  import mito_pkg::*;
#(
  parameter int TILE_W     = 8,
  parameter int CONV_TILES = 16,
  parameter int POOL_TILES = 4,
  parameter int FC_TILES   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        layer_type,
  input  logic              rd_done,
  input  logic              comp_done,
  input  logic              wr_done,
  input  logic              ofm_full,
  output logic [3:0]        phase,
  output logic [1:0]        cur_layer,
  output logic [TILE_W-1:0] tile_idx,
  output logic              rd_req,
  output logic              comp_start,
  output logic              wr_req,
  output logic              ofm_valid,
  output logic              busy
);

  localparam logic [TILE_W-1:0] CONV_LAST = TILE_W'(CONV_TILES - 1);
  localparam logic [TILE_W-1:0] POOL_LAST = TILE_W'(POOL_TILES - 1);
  localparam logic [TILE_W-1:0] FC_LAST   = TILE_W'(FC_TILES - 1);

  phase_t            r_phase;
  phase_t            w_next;
  logic [1:0]        r_cur_layer;
  logic [1:0]        r_done_layer;
  logic              r_comp_start;
  logic              w_start;
  logic              w_load;
  logic              w_inc;
  logic              w_last;
  logic [TILE_W-1:0] w_idx;
  logic [TILE_W-1:0] w_last_idx;

  assign w_start = (r_phase == PH_IDLE) &&
                   layer_startable(layer_type, r_done_layer);

  always_comb begin
    w_last_idx = CONV_LAST;
    unique case (layer_type)
      LAYER_POOL: w_last_idx = POOL_LAST;
      LAYER_FC:   w_last_idx = FC_LAST;
      default:    w_last_idx = CONV_LAST;
    endcase
  end

  tile_counter #(
    .TILE_W (TILE_W)
  ) u_tile_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_inc      (w_inc),
    .i_last_idx (w_last_idx),
    .o_idx      (w_idx),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= PH_IDLE;
    else     r_phase <= w_next;
  end

  always_comb begin
    w_next = r_phase;
    w_load = 1'b0;
    w_inc  = 1'b0;
    unique case (r_phase)
      PH_IDLE: begin
        if (w_start) begin
          w_next = PH_INIT;
          w_load = 1'b1;
        end
      end
      PH_INIT: w_next = PH_READ;
      PH_READ: begin
        if (rd_done) w_next = PH_COMP;
      end
      PH_COMP: begin
        if (comp_done) w_next = PH_WRITE;
      end
      PH_WRITE: begin
        // A full buffer outranks a coincident wr_done.
        if (ofm_full) begin
          w_next = PH_SUSPEND;
        end else if (wr_done) begin
          if (w_last) begin
            w_next = PH_FINISH;
          end else begin
            w_next = PH_READ;
            w_inc  = 1'b1;
          end
        end
      end
      PH_SUSPEND: begin
        if (!ofm_full) w_next = PH_WRITE;
      end
      PH_FINISH: w_next = PH_IDLE;
      default:   w_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_layer  <= LAYER_NONE;
      r_done_layer <= LAYER_NONE;
      r_comp_start <= 1'b0;
    end else begin
      if (w_start) r_cur_layer <= layer_type;
      // Remember the finished layer until the controller moves on,
      // so the stale layer_type cannot relaunch it.
      if (r_phase == PH_FINISH)
        r_done_layer <= r_cur_layer;
      else if (layer_type == LAYER_NONE)
        r_done_layer <= LAYER_NONE;
      // COMP is only entered from READ, so this marks its first cycle.
      r_comp_start <= (r_phase == PH_READ) && rd_done;
    end
  end

  assign phase      = r_phase;
  assign cur_layer  = r_cur_layer;
  assign tile_idx   = w_idx;
  assign rd_req     = (r_phase == PH_READ);
  assign wr_req     = (r_phase == PH_WRITE);
  assign comp_start = r_comp_start;
  assign ofm_valid  = (r_phase == PH_FINISH);
  assign busy       = (r_phase != PH_IDLE);

endmodule

// File: tb/tb_layer_phase_sequencer.sv
// Directed bench for layer_phase_sequencer.
// Instant/slow done responders, buffer stall, controller chain, resets.
module tb_layer_phase_sequencer;
  import mito_pkg::*;

  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    layer_type;
  logic          rd_done;
  logic          comp_done;
  logic          wr_done;
  logic          ofm_full;
  logic [3:0]    phase;
  logic [1:0]    cur_layer;
  logic [TW-1:0] tile_idx;
  logic          rd_req;
  logic          comp_start;
  logic          wr_req;
  logic          ofm_valid;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;

  int resp_en  = 0;
  int rd_delay = 0;
  int rd_cnt   = 0;

  int n_init = 0;
  int n_comp = 0;
  int n_ofm  = 0;
  int n_rd   = 0;
  int n_susp = 0;

  layer_phase_sequencer #(
    .TILE_W     (TW),
    .CONV_TILES (2),
    .POOL_TILES (4),
    .FC_TILES   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .layer_type (layer_type),
    .rd_done    (rd_done),
    .comp_done  (comp_done),
    .wr_done    (wr_done),
    .ofm_full   (ofm_full),
    .phase      (phase),
    .cur_layer  (cur_layer),
    .tile_idx   (tile_idx),
    .rd_req     (rd_req),
    .comp_start (comp_start),
    .wr_req     (wr_req),
    .ofm_valid  (ofm_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Done responders, driven mid-cycle from the current phase.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en != 0) begin
        if (phase == PH_READ) begin
          rd_done = (rd_cnt >= rd_delay);
          rd_cnt++;
        end else begin
          rd_done = 1'b0;
          rd_cnt  = 0;
        end
        comp_done = (phase == PH_COMP);
        wr_done   = (phase == PH_WRITE);
      end
    end
  end

  // Cumulative event counters, updated just after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (phase == PH_INIT)    n_init++;
      if (comp_start)          n_comp++;
      if (ofm_valid)           n_ofm++;
      if (rd_req)              n_rd++;
      if (phase == PH_SUSPEND) n_susp++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic wait_phase(input logic [3:0] p, input int budget);
    int k;
    k = 0;
    while (phase != p && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (phase != p) check("wait_timeout", 32'(phase), 32'(p));
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'h0);
    check({tag, "_outs"},
          32'({cur_layer, tile_idx, rd_req, comp_start,
               wr_req, ofm_valid, busy}), 32'h0);
  endtask

  logic [3:0] exp_ph [8];
  logic [1:0] exp_ti [8];
  int s_init, s_comp, s_ofm, s_rd, s_susp;
  logic [5:0] seq;
  int k;

  initial begin
    exp_ph = '{4'h7, 4'h4, 4'h5, 4'h6, 4'h4, 4'h5, 4'h6, 4'h9};
    exp_ti = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

    // Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      layer_type = 2'($urandom);
      rd_done    = 1'($urandom);
      comp_done  = 1'($urandom);
      wr_done    = 1'($urandom);
      ofm_full   = 1'($urandom);
      @(negedge clk);
      check_idle_outs("reset");
    end
    layer_type = LAYER_NONE;
    rd_done    = 1'b0;
    comp_done  = 1'b0;
    wr_done    = 1'b0;
    ofm_full   = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    check_idle_outs("post_reset");
    resp_en = 1;
    @(negedge clk);

    // Short CONV layer, N=2, instant responders.
    layer_type = LAYER_CONV;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("conv_ph%0d", i + 1), 32'(phase), 32'(exp_ph[i]));
      check($sformatf("conv_ti%0d", i + 1), 32'(tile_idx),
            32'(exp_ti[i]));
      check($sformatf("conv_ov%0d", i + 1), 32'(ofm_valid),
            32'(i == 7));
      check($sformatf("conv_cs%0d", i + 1), 32'(comp_start),
            32'(i == 2 || i == 5));
      check($sformatf("conv_rq%0d", i + 1), 32'({rd_req, wr_req}),
            32'({i == 1 || i == 4, i == 3 || i == 6}));
    end
    check("conv_layer", 32'(cur_layer), 32'(LAYER_CONV));
    @(negedge clk);
    check("conv_done_idle", 32'(phase), 32'(PH_IDLE));
    @(negedge clk);
    check("conv_no_restart", 32'({phase, busy}), 32'h0);
    layer_type = LAYER_NONE;
    @(negedge clk);

    // POOL layer, N=4, buffer full on tile 1.
    s_comp = n_comp;
    s_ofm  = n_ofm;
    s_init = n_init;
    s_susp = n_susp;
    layer_type = LAYER_POOL;
    k = 0;
    while (!(phase == PH_WRITE && tile_idx == 2'd1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("full_reach_write", 32'({phase, tile_idx}),
          32'({PH_WRITE, 2'd1}));
    ofm_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("susp_ph%0d", i), 32'(phase), 32'(PH_SUSPEND));
      check($sformatf("susp_req%0d", i), 32'({rd_req, wr_req}), 32'h0);
      check($sformatf("susp_ti%0d", i), 32'(tile_idx), 32'd1);
      if (i == 5) ofm_full = 1'b0;
    end
    @(negedge clk);
    check("resume_write", 32'({phase, tile_idx, wr_req}),
          32'({PH_WRITE, 2'd1, 1'b1}));
    wait_phase(PH_FINISH, 100);
    check("pool_last_tile", 32'(tile_idx), 32'd3);
    check("pool_layer", 32'(cur_layer), 32'(LAYER_POOL));
    @(negedge clk);
    check("pool_comp_pulses", 32'(n_comp - s_comp), 32'd4);
    check("pool_ofm_pulses", 32'(n_ofm - s_ofm), 32'd1);
    check("pool_inits", 32'(n_init - s_init), 32'd1);
    check("pool_susp_cycles", 32'(n_susp - s_susp), 32'd5);

    // FC layer, N=1, slow read and a mid-layer layer_type change.
    s_rd   = n_rd;
    s_comp = n_comp;
    s_ofm  = n_ofm;
    rd_delay   = 4;
    layer_type = LAYER_FC;
    wait_phase(PH_COMP, 50);
    layer_type = LAYER_CONV;
    @(negedge clk);
    layer_type = LAYER_NONE;
    wait_phase(PH_FINISH, 50);
    check("fc_layer_kept", 32'(cur_layer), 32'(LAYER_FC));
    @(negedge clk);
    check("slow_rd_cycles", 32'(n_rd - s_rd), 32'd5);
    check("slow_comp_pulses", 32'(n_comp - s_comp), 32'd1);
    check("slow_ofm_pulses", 32'(n_ofm - s_ofm), 32'd1);
    rd_delay = 0;
    @(negedge clk);
    @(negedge clk);
    check("fc_idle_after", 32'({phase, busy}), 32'h0);

    // Controller chain: 01 -> 10 -> 11 -> 00, advanced on ofm_valid.
    s_init = n_init;
    s_ofm  = n_ofm;
    s_comp = n_comp;
    seq    = '0;
    layer_type = LAYER_CONV;
    k = 0;
    while (layer_type != LAYER_NONE && k < 300) begin
      @(negedge clk);
      k++;
      if (ofm_valid) begin
        seq = {seq[3:0], cur_layer};
        layer_type = (layer_type == LAYER_FC) ? LAYER_NONE
                                              : layer_type + 2'd1;
      end
    end
    check("chain_end", 32'(layer_type), 32'(LAYER_NONE));
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("chain_order", 32'(seq), 32'(6'b01_10_11));
    check("chain_inits", 32'(n_init - s_init), 32'd3);
    check("chain_ofm", 32'(n_ofm - s_ofm), 32'd3);
    check("chain_comp", 32'(n_comp - s_comp), 32'd7);
    check("chain_idle", 32'({phase, busy}), 32'h0);

    // Asynchronous reset during COMP.
    layer_type = LAYER_CONV;
    wait_phase(PH_COMP, 50);
    #2 rst = 1'b1;
    #1;
    check("arst_phase", 32'(phase), 32'(PH_IDLE));
    check("arst_outs", 32'({busy, comp_start, tile_idx, cur_layer}), 32'h0);
    layer_type = LAYER_NONE;
    @(negedge clk);
    rst = 1'b0;
    s_comp = n_comp;
    s_ofm  = n_ofm;
    s_init = n_init;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("arst_no_comp", 32'(n_comp - s_comp), 32'd0);
    check("arst_no_ofm", 32'(n_ofm - s_ofm), 32'd0);
    check("arst_no_init", 32'(n_init - s_init), 32'd0);
    check("arst_idle", 32'({phase, busy}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
